wb_load_unit: RTL and testbench

- Parametrised, registered write-back stage for the RISC-V datapath.
- Selects the register-file write data from the ALU, PC, shifter, constants or memory.
- For loads, waits for memory data through a valid handshake, extracts the addressed byte lane and sign- or zero-extends it.
- Flags misaligned loads and memory timeouts; presents the result to the register file through a valid/ready handshake.

---
 rtl/wb_pkg.sv | 51 +++++
 rtl/wb_load_unit_load_extract.sv | 41 ++++
 rtl/wb_load_unit.sv | 159 +++++++++++++++
 tb/tb_wb_load_unit.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared select encoding, FSM state type and load-decode helpers for the
// write-back stage.
package wb_pkg;

    typedef enum logic [3:0] {
        SEL_ALU   = 4'b0000,
        SEL_ONE   = 4'b0010,
        SEL_ZERO  = 4'b0011,
        SEL_PC    = 4'b0100,
        SEL_LD    = 4'b0101,
        SEL_LB    = 4'b0110,
        SEL_LH    = 4'b0111,
        SEL_LW    = 4'b1000,
        SEL_LBU   = 4'b1001,
        SEL_LHU   = 4'b1010,
        SEL_LWU   = 4'b1011,
        SEL_SHIFT = 4'b1100
    } wb_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_MEM = 2'd1,
        ST_OUT      = 2'd2
    } wb_state_e;

    function automatic logic is_load(input logic [3:0] sel);
        case (sel)
            SEL_LD, SEL_LB, SEL_LH, SEL_LW,
            SEL_LBU, SEL_LHU, SEL_LWU: is_load = 1'b1;
            default:                   is_load = 1'b0;
        endcase
    endfunction

    // Non-load codes report 8 so the caller's size clamp handles them uniformly.
    function automatic logic [3:0] access_bytes(input logic [3:0] sel);
        case (sel)
            SEL_LB, SEL_LBU: access_bytes = 4'd1;
            SEL_LH, SEL_LHU: access_bytes = 4'd2;
            SEL_LW, SEL_LWU: access_bytes = 4'd4;
            default:         access_bytes = 4'd8;
        endcase
    endfunction

    function automatic logic is_signed_load(input logic [3:0] sel);
        case (sel)
            SEL_LB, SEL_LH, SEL_LW: is_signed_load = 1'b1;
            default:                is_signed_load = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/wb_load_unit_load_extract.sv
// Combinational byte-lane extraction with sign/zero extension and an
// alignment check for the addressed load.
module load_extract
    import wb_pkg::*;
#(
    parameter  int XLEN  = 64,
    localparam int OFF_W = $clog2(XLEN/8)
) (
    input  logic [XLEN-1:0]  mem_data_i,
    input  logic [OFF_W-1:0] offset_i,
    input  logic [3:0]       sel_i,
    output logic [XLEN-1:0]  data_o,
    output logic             misaligned_o
);

    localparam int XB = XLEN/8;
    localparam int IW = $clog2(XLEN);

    logic [3:0]       nbytes;
    logic [XLEN-1:0]  lane;
    logic [IW-1:0]    msb;
    logic [OFF_W-1:0] mask;
    logic             fill;

    always_comb begin
        nbytes = access_bytes(sel_i);
        // A doubleword on a 32-bit datapath is simply the full word.
        if (int'(nbytes) > XB) begin
            nbytes = 4'(XB);
        end
        lane = mem_data_i >> {offset_i, 3'b000};
        msb  = IW'(8 * int'(nbytes) - 1);
        fill = is_signed_load(sel_i) & lane[msb];
        for (int i = 0; i < XLEN; i++) begin
            data_o[i] = (i > int'(msb)) ? fill : lane[i];
        end
        mask         = OFF_W'(nbytes - 4'd1);
        misaligned_o = is_load(sel_i) && (|(offset_i & mask));
    end

endmodule

// File: rtl/wb_load_unit.sv
// Registered write-back stage: source select, load wait with timeout,
// lane extraction and a valid/ready result handshake.
module wb_load_unit
    import wb_pkg::*;
#(
    parameter  int XLEN        = 64,
    parameter  int TIMEOUT_CYC = 255,
    localparam int OFF_W       = $clog2(XLEN/8)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             REQ_VALID,
    output logic             REQ_READY,
    input  logic [3:0]       REQ_SEL,
    input  logic [OFF_W-1:0] REQ_OFFSET,
    input  logic [XLEN-1:0]  ALU_OUT,
    input  logic [XLEN-1:0]  PC,
    input  logic [XLEN-1:0]  SHIFT_OUT,
    input  logic             MEM_VALID,
    input  logic [XLEN-1:0]  MEM_DATA,
    output logic             WB_VALID,
    input  logic             WB_READY,
    output logic [XLEN-1:0]  WB_DATA,
    output logic             WB_ERR,
    output logic             WB_ERR_TO
);

    // state    | meaning
    // IDLE     | no request held, ready for a new one
    // WAIT_MEM | aligned load issued, waiting for MEM_VALID or timeout
    // OUT      | result presented, held until WB_READY

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYC - 1);

    wb_state_e        state_q, state_d;
    logic [3:0]       sel_q, sel_d;
    logic [OFF_W-1:0] off_q, off_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [XLEN-1:0]  data_q, data_d;
    logic             err_q, err_d;
    logic             to_q, to_d;
    logic             valid_q, valid_d;

    logic             accept;
    logic [3:0]       ext_sel;
    logic [OFF_W-1:0] ext_off;
    logic [XLEN-1:0]  ext_data;
    logic             ext_mis;
    logic [XLEN-1:0]  nonload_data;

    // The single extractor checks alignment at acceptance and extracts in WAIT_MEM.
    assign ext_sel = (state_q == ST_WAIT_MEM) ? sel_q : REQ_SEL;
    assign ext_off = (state_q == ST_WAIT_MEM) ? off_q : REQ_OFFSET;

    load_extract #(.XLEN(XLEN)) u_extract (
        .mem_data_i   (MEM_DATA),
        .offset_i     (ext_off),
        .sel_i        (ext_sel),
        .data_o       (ext_data),
        .misaligned_o (ext_mis)
    );

    always_comb begin
        nonload_data = '0;
        case (REQ_SEL)
            SEL_ALU:   nonload_data = ALU_OUT;
            SEL_ONE:   nonload_data = XLEN'(1);
            SEL_PC:    nonload_data = PC;
            SEL_SHIFT: nonload_data = SHIFT_OUT;
            default:   nonload_data = '0;
        endcase
    end

    assign REQ_READY = (state_q == ST_IDLE) || ((state_q == ST_OUT) && WB_READY);
    assign accept    = REQ_VALID && REQ_READY;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        off_d   = off_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        err_d   = err_q;
        to_d    = to_q;

        case (state_q)
            ST_WAIT_MEM: begin
                if (MEM_VALID) begin
                    data_d  = ext_data;
                    err_d   = 1'b0;
                    to_d    = 1'b0;
                    state_d = ST_OUT;
                end else if (cnt_q == CNT_LAST) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    to_d    = 1'b1;
                    state_d = ST_OUT;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_OUT: begin
                if (WB_READY) begin
                    state_d = ST_IDLE;
                end
            end
            default: ;
        endcase

        if (accept) begin
            sel_d = REQ_SEL;
            off_d = REQ_OFFSET;
            if (!is_load(REQ_SEL)) begin
                data_d  = nonload_data;
                err_d   = 1'b0;
                to_d    = 1'b0;
                state_d = ST_OUT;
            end else if (ext_mis) begin
                data_d  = '0;
                err_d   = 1'b1;
                to_d    = 1'b0;
                state_d = ST_OUT;
            end else begin
                cnt_d   = '0;
                state_d = ST_WAIT_MEM;
            end
        end

        valid_d = (state_d == ST_OUT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            off_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            to_q    <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            off_q   <= off_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            err_q   <= err_d;
            to_q    <= to_d;
            valid_q <= valid_d;
        end
    end

    assign WB_VALID  = valid_q;
    assign WB_DATA   = data_q;
    assign WB_ERR    = err_q;
    assign WB_ERR_TO = to_q;

endmodule

// File: tb/tb_wb_load_unit.sv
// Bench for wb_load_unit (XLEN=64, TIMEOUT_CYC=8) plus standalone vectors for
// load_extract at both datapath widths.
module tb_wb_load_unit;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        REQ_VALID, REQ_READY;
    logic [3:0]  REQ_SEL;
    logic [2:0]  REQ_OFFSET;
    logic [63:0] ALU_OUT, PC, SHIFT_OUT, MEM_DATA, WB_DATA;
    logic        MEM_VALID, WB_VALID, WB_READY, WB_ERR, WB_ERR_TO;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    wb_load_unit #(.XLEN(64), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset(reset),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_SEL(REQ_SEL),
        .REQ_OFFSET(REQ_OFFSET), .ALU_OUT(ALU_OUT), .PC(PC), .SHIFT_OUT(SHIFT_OUT),
        .MEM_VALID(MEM_VALID), .MEM_DATA(MEM_DATA),
        .WB_VALID(WB_VALID), .WB_READY(WB_READY), .WB_DATA(WB_DATA),
        .WB_ERR(WB_ERR), .WB_ERR_TO(WB_ERR_TO)
    );

    logic [63:0] x_data, x_out;
    logic [2:0]  x_off;
    logic [3:0]  x_sel;
    logic        x_mis;
    load_extract #(.XLEN(64)) u_ext64 (
        .mem_data_i(x_data), .offset_i(x_off), .sel_i(x_sel),
        .data_o(x_out), .misaligned_o(x_mis)
    );

    logic [31:0] y_data, y_out;
    logic [1:0]  y_off;
    logic [3:0]  y_sel;
    logic        y_mis;
    load_extract #(.XLEN(32)) u_ext32 (
        .mem_data_i(y_data), .offset_i(y_off), .sel_i(y_sel),
        .data_o(y_out), .misaligned_o(y_mis)
    );

    typedef struct {
        logic [63:0] d;
        logic [2:0]  off;
        logic [3:0]  sel;
        logic [63:0] exp;
        logic        mis;
    } xv_t;

    xv_t xv [13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level reference: result, error flags and cycles from
    // acceptance to WB_VALID. m is the WAIT_MEM cycle carrying MEM_VALID.
    task automatic model(input logic [3:0] sel, input logic [2:0] off,
                         input logic [63:0] alu, input logic [63:0] pc,
                         input logic [63:0] sh, input logic [63:0] md, input int m,
                         output logic [63:0] ed, output logic ee, output logic et,
                         output int el);
        int          nb;
        logic        sg;
        logic [63:0] lane, span;
        ed = '0; ee = 1'b0; et = 1'b0; el = 0; nb = 0; sg = 1'b0;
        case (sel)
            4'd0:  ed = alu;
            4'd2:  ed = 64'd1;
            4'd4:  ed = pc;
            4'd12: ed = sh;
            4'd5:  nb = 8;
            4'd6:  begin nb = 1; sg = 1'b1; end
            4'd7:  begin nb = 2; sg = 1'b1; end
            4'd8:  begin nb = 4; sg = 1'b1; end
            4'd9:  nb = 1;
            4'd10: nb = 2;
            4'd11: nb = 4;
            default: ;
        endcase
        if (nb != 0) begin
            if ((int'(off) % nb) != 0) begin
                ee = 1'b1;
            end else if (m < 1 || m > TO) begin
                ee = 1'b1; et = 1'b1; el = TO;
            end else begin
                lane = md >> (8 * int'(off));
                if (nb < 8) begin
                    span = 64'd1 << (8 * nb);
                    lane = lane % span;
                    if (sg && lane >= span / 2) lane = lane - span;
                end
                ed = lane;
                el = m;
            end
        end
    endtask

    task automatic do_txn(input logic [3:0] sel, input logic [2:0] off,
                          input logic [63:0] md, input int m, input int hold);
        logic [63:0] alu, pc, sh, ed;
        logic        ee, et;
        int          el, lat;
        alu = {$urandom, $urandom};
        pc  = {$urandom, $urandom};
        sh  = {$urandom, $urandom};
        model(sel, off, alu, pc, sh, md, m, ed, ee, et, el);
        REQ_SEL = sel; REQ_OFFSET = off; ALU_OUT = alu; PC = pc; SHIFT_OUT = sh;
        REQ_VALID = 1'b1; WB_READY = 1'b0;
        #1;
        chk("req_ready_idle", 64'(REQ_READY), 64'd1);
        step();
        REQ_VALID = 1'b0;
        ALU_OUT = {$urandom, $urandom}; PC = {$urandom, $urandom}; SHIFT_OUT = {$urandom, $urandom};
        lat = 0;
        while (!WB_VALID && lat < 20) begin
            lat++;
            MEM_VALID = (lat == m);
            MEM_DATA  = (lat == m) ? md : {$urandom, $urandom};
            step();
        end
        MEM_VALID = 1'b0;
        chk("latency", 64'(lat), 64'(el));
        chk("wb_data", WB_DATA, ed);
        chk("wb_err", 64'(WB_ERR), 64'(ee));
        chk("wb_err_to", 64'(WB_ERR_TO), 64'(et));
        for (int h = 0; h < hold; h++) begin
            MEM_VALID = 1'b1;
            MEM_DATA  = {$urandom, $urandom};
            step();
            chk("hold_valid", 64'(WB_VALID), 64'd1);
            chk("hold_data", WB_DATA, ed);
            chk("hold_err", 64'({WB_ERR, WB_ERR_TO}), 64'({ee, et}));
            chk("hold_req_ready", 64'(REQ_READY), 64'd0);
        end
        MEM_VALID = 1'b0;
        WB_READY  = 1'b1;
        step();
        WB_READY = 1'b0;
        chk("valid_drop", 64'(WB_VALID), 64'd0);
    endtask

    initial begin
        xv[0]  = '{64'h00000000_80000000, 3'd3, 4'b0110, 64'hFFFFFFFF_FFFFFF80, 1'b0};
        xv[1]  = '{64'hBEEF0000_00000000, 3'd6, 4'b1010, 64'h00000000_0000BEEF, 1'b0};
        xv[2]  = '{64'hBEEF0000_00000000, 3'd4, 4'b1011, 64'h00000000_BEEF0000, 1'b0};
        xv[3]  = '{64'hBEEF0000_00000000, 3'd4, 4'b1000, 64'hFFFFFFFF_BEEF0000, 1'b0};
        xv[4]  = '{64'h01234567_89ABCDEF, 3'd0, 4'b0101, 64'h01234567_89ABCDEF, 1'b0};
        xv[5]  = '{64'h01234567_89ABCDEF, 3'd1, 4'b1001, 64'h00000000_000000CD, 1'b0};
        xv[6]  = '{64'h01234567_89ABCDEF, 3'd7, 4'b0110, 64'h00000000_00000001, 1'b0};
        xv[7]  = '{64'h01234567_89ABCDEF, 3'd2, 4'b0111, 64'hFFFFFFFF_FFFF89AB, 1'b0};
        xv[8]  = '{64'h01234567_89ABCDEF, 3'd5, 4'b0110, 64'h00000000_00000045, 1'b0};
        xv[9]  = '{64'h01234567_89ABCDEF, 3'd4, 4'b1010, 64'h00000000_00004567, 1'b0};
        xv[10] = '{64'h01234567_89ABCDEF, 3'd2, 4'b1000, 64'h0, 1'b1};
        xv[11] = '{64'h01234567_89ABCDEF, 3'd1, 4'b0111, 64'h0, 1'b1};
        xv[12] = '{64'h01234567_89ABCDEF, 3'd4, 4'b0101, 64'h0, 1'b1};

        reset = 1'b1; REQ_VALID = 1'b0; REQ_SEL = '0; REQ_OFFSET = '0;
        ALU_OUT = '0; PC = '0; SHIFT_OUT = '0; MEM_VALID = 1'b0; MEM_DATA = '0;
        WB_READY = 1'b0;

        for (int i = 0; i < 13; i++) begin
            x_data = xv[i].d; x_off = xv[i].off; x_sel = xv[i].sel;
            #1;
            chk($sformatf("ext64_mis[%0d]", i), 64'(x_mis), 64'(xv[i].mis));
            if (!xv[i].mis) chk($sformatf("ext64_data[%0d]", i), x_out, xv[i].exp);
        end
        y_data = 32'h89ABCDEF;
        y_sel = 4'b0101; y_off = 2'd0; #1;
        chk("ext32_ld", 64'(y_out), 64'h89ABCDEF);
        y_sel = 4'b1011; #1;
        chk("ext32_lwu", 64'(y_out), 64'h89ABCDEF);
        y_sel = 4'b0101; y_off = 2'd2; #1;
        chk("ext32_ld_mis", 64'(y_mis), 64'd1);
        y_sel = 4'b0111; #1;
        chk("ext32_lh", 64'(y_out), 64'hFFFF89AB);

        repeat (3) step();
        chk("rst_valid", 64'(WB_VALID), 64'd0);
        chk("rst_data", WB_DATA, 64'd0);
        chk("rst_err", 64'({WB_ERR, WB_ERR_TO}), 64'd0);
        reset = 1'b0;
        #1;
        chk("rst_req_ready", 64'(REQ_READY), 64'd1);
        step();

        // ALU then back-to-back SHIFT and const-1 with WB_READY held high.
        REQ_SEL = 4'b0000; ALU_OUT = 64'h1234; REQ_VALID = 1'b1;
        step();
        chk("b2b_alu_valid", 64'(WB_VALID), 64'd1);
        chk("b2b_alu_data", WB_DATA, 64'h1234);
        chk("b2b_alu_err", 64'(WB_ERR), 64'd0);
        REQ_SEL = 4'b1100; SHIFT_OUT = 64'hA5A50000_00005A5A; WB_READY = 1'b1;
        #1;
        chk("b2b_req_ready", 64'(REQ_READY), 64'd1);
        step();
        chk("b2b_shift_valid", 64'(WB_VALID), 64'd1);
        chk("b2b_shift_data", WB_DATA, 64'hA5A50000_00005A5A);
        REQ_SEL = 4'b0010;
        step();
        chk("b2b_one_data", WB_DATA, 64'd1);
        REQ_VALID = 1'b0;
        step();
        chk("b2b_idle", 64'(WB_VALID), 64'd0);
        WB_READY = 1'b0;

        do_txn(4'b0110, 3'd3, 64'h00000000_80000000, 4, 0);
        do_txn(4'b1010, 3'd6, 64'hBEEF0000_00000000, 2, 0);
        do_txn(4'b1011, 3'd4, 64'hBEEF0000_00000000, 1, 0);
        do_txn(4'b1000, 3'd2, 64'h01234567_89ABCDEF, 1, 3);
        do_txn(4'b0101, 3'd0, 64'h01234567_89ABCDEF, 99, 2);
        do_txn(4'b0101, 3'd0, 64'h01234567_89ABCDEF, TO, 0);
        do_txn(4'b0000, 3'd0, 64'h0, 0, 5);

        // Reset while waiting on memory abandons the load.
        REQ_SEL = 4'b0101; REQ_OFFSET = 3'd0; REQ_VALID = 1'b1;
        step();
        REQ_VALID = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst_valid", 64'(WB_VALID), 64'd0);
        chk("midrst_data", WB_DATA, 64'd0);
        chk("midrst_err", 64'({WB_ERR, WB_ERR_TO}), 64'd0);
        chk("midrst_req_ready", 64'(REQ_READY), 64'd1);
        MEM_VALID = 1'b1; MEM_DATA = 64'hDEADBEEF_CAFEF00D;
        step();
        MEM_VALID = 1'b0;
        chk("midrst_late_mem", 64'(WB_VALID), 64'd0);
        step();
        chk("midrst_late_mem2", 64'(WB_VALID), 64'd0);

        for (int t = 0; t < 60; t++) begin
            do_txn(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                   {$urandom, $urandom}, int'($urandom_range(1, 10)),
                   int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
